// File: rtl/ram_responder_pkg.sv
// ram_responder shared definitions.
// FSM state encoding, depth helper and default clear value.
package ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        CLEAR  = 2'd3
    } state_e;

    localparam int DEF_FILL = 0;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ram_responder_ram_array.sv
// ram_array: single-port sync-write/sync-read storage.
// Ports: clk, rst (read register only), en, we, addr, wdata, rdata.
module ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    // Read register holds the last read word between reads.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory target with wait states and self-clear.
// Ports: clk, rst, select/write/address/data_in, clear;
//        data_out, ack, busy, clear_done.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] FILL = DATA_W'(DEF_FILL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              busy,
    output logic              clear_done
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    assign busy = (state != IDLE);

    // A reset landing on an access/clear edge must not touch memory.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = data_q;
        if (!rst) begin
            unique case (1'b1)
                (state == ACCESS): begin
                    ram_en = 1'b1;
                    ram_we = wr_q;
                end
                (state == CLEAR): begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = clr_cnt;
                    ram_wdata = FILL;
                end
                default: ;
            endcase
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack        <= 1'b0;
            clear_done <= 1'b0;
            wait_cnt   <= '0;
            clr_cnt    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            ack        <= 1'b0;
            clear_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (select) begin
                        wr_q   <= write;
                        addr_q <= address;
                        data_q <= data_in;
                        if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= ACCESS;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ACCESS: begin
                    ack   <= 1'b1;
                    state <= IDLE;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        clear_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder.
// Instance 0 has no wait states, instance 1 has three.
module tb_ram_responder;

    logic            clk = 1'b0;
    logic [1:0]      rst;
    logic [1:0]      sel;
    logic [1:0]      wr;
    logic [1:0]      clr;
    logic [1:0][9:0] addr;
    logic [1:0][7:0] din;
    logic [1:0][7:0] dout;
    logic [1:0]      ack;
    logic [1:0]      busy;
    logic [1:0]      cdone;

    always #5 clk = ~clk;

    ram_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst[0]),
        .select     (sel[0]),
        .write      (wr[0]),
        .address    (addr[0]),
        .data_in    (din[0]),
        .clear      (clr[0]),
        .data_out   (dout[0]),
        .ack        (ack[0]),
        .busy       (busy[0]),
        .clear_done (cdone[0])
    );

    ram_responder #(.WAIT_STATES(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst[1]),
        .select     (sel[1]),
        .write      (wr[1]),
        .address    (addr[1]),
        .data_in    (din[1]),
        .clear      (clr[1]),
        .data_out   (dout[1]),
        .ack        (ack[1]),
        .busy       (busy[1]),
        .clear_done (cdone[1])
    );

    typedef struct {
        int         d;
        bit         rd;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model [2][1024];
    int         cd_exp [2] = '{-1, -1};
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Ack monitor: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && cdone[d])
                chk("ack_cd_excl", 32'(d), 32'd99);
            if (ack[d]) begin
                chk("ack_busy", 32'(busy[d]), 32'd0);
                if (sbq.size() == 0) begin
                    chk("spurious_ack", 32'(d), 32'd99);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_dut", 32'(d), 32'(e.d));
                    chk("ack_cyc", 32'(cyc), 32'(e.due));
                    if (e.rd)
                        chk("rdata", 32'(dout[d]), 32'(e.data));
                end
            end
            if (cdone[d]) begin
                chk("cd_cyc", 32'(cyc), 32'(cd_exp[d]));
                chk("cd_busy", 32'(busy[d]), 32'd0);
                cd_exp[d] = -1;
            end
        end
    end

    task automatic push(input int d, input bit rd,
                        input logic [9:0] a);
        exp_t e;
        e.d    = d;
        e.rd   = rd;
        e.data = model[d][a];
        e.due  = cyc + 2 + ws(d);
        sbq.push_back(e);
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while ((sbq.size() != 0 || busy[d]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200)
            chk("idle_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic req(input int d, input bit w,
                       input logic [9:0] a,
                       input logic [7:0] v);
        sel[d]  = 1'b1;
        wr[d]   = w;
        addr[d] = a;
        din[d]  = v;
        push(d, !w, a);
        if (w) model[d][a] = v;
        @(negedge clk);
        sel[d] = 1'b0;
        chk("busy_accept", 32'(busy[d]), 32'd1);
        wait_idle(d);
    endtask

    // select stays high; a new request is presented in each ack cycle.
    task automatic stream(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            logic [7:0] v;
            v = (d == 0) ? 8'(2 * k) : 8'(k ^ 8'h5A);
            sel[d]  = 1'b1;
            wr[d]   = 1'b1;
            addr[d] = 10'(k);
            din[d]  = v;
            push(d, 1'b0, 10'(k));
            model[d][k] = v;
            @(negedge clk);
            if (k == n - 1) sel[d] = 1'b0;
            while (busy[d] && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("stream_stall", 32'(t), 32'd0);
        end
        wait_idle(d);
    endtask

    task automatic wait_clear(input int d);
        int t = 0;
        while (cd_exp[d] != -1 && t < 1200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1200)
            chk("clear_timeout", 32'(cd_exp[d]), 32'hFFFF_FFFF);
    endtask

    initial begin
        rst  = 2'b11;
        sel  = '0;
        wr   = '0;
        clr  = '0;
        addr = '0;
        din  = '0;
        repeat (3) @(negedge clk);
        rst = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk("rst_dout", 32'(dout[d]), 32'd0);
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_cdone", 32'(cdone[d]), 32'd0);
        end

        // Single write then read, no wait states.
        req(0, 1'b1, 10'd10, 8'd20);
        req(0, 1'b0, 10'd10, 8'd0);
        chk("rd10_hold", 32'(dout[0]), 32'd20);

        // Streamed fill of the whole array, then random reads.
        stream(0, 1024);
        req(0, 1'b0, 10'd700, 8'd0);
        chk("rd700", 32'(dout[0]), 32'd120);
        for (int i = 0; i < 20; i++)
            req(0, 1'b0, 10'($urandom_range(0, 1023)), 8'd0);

        // Clear with a simultaneous select: clear wins, no ack.
        clr[0]  = 1'b1;
        sel[0]  = 1'b1;
        wr[0]   = 1'b1;
        addr[0] = 10'd3;
        din[0]  = 8'hFF;
        cd_exp[0] = cyc + 1025;
        @(negedge clk);
        clr[0] = 1'b0;
        sel[0] = 1'b0;
        chk("busy_clear", 32'(busy[0]), 32'd1);
        wait_clear(0);
        for (int k = 0; k < 1024; k++) model[0][k] = 8'h00;
        req(0, 1'b0, 10'd0, 8'd0);
        req(0, 1'b0, 10'd511, 8'd0);
        req(0, 1'b0, 10'd1023, 8'd0);
        req(0, 1'b0, 10'd3, 8'd0);

        // Three wait states: streamed writes, then reads.
        stream(1, 16);
        req(1, 1'b1, 10'd5, 8'h5A);
        sel[1]  = 1'b1;
        wr[1]   = 1'b0;
        addr[1] = 10'd5;
        push(1, 1'b1, 10'd5);
        @(negedge clk);
        sel[1]  = 1'b0;
        wr[1]   = 1'b1;
        addr[1] = 10'd6;
        din[1]  = 8'hEE;
        chk("busy_w0", 32'(busy[1]), 32'd1);
        @(negedge clk);
        sel[1] = 1'b1;
        chk("busy_w1", 32'(busy[1]), 32'd1);
        @(negedge clk);
        addr[1] = 10'd7;
        chk("busy_w2", 32'(busy[1]), 32'd1);
        @(negedge clk);
        sel[1] = 1'b0;
        chk("busy_w3", 32'(busy[1]), 32'd1);
        wait_idle(1);
        req(1, 1'b0, 10'd6, 8'd0);
        req(1, 1'b0, 10'd7, 8'd0);

        // Reset partway through a clear.
        req(1, 1'b1, 10'd100, 8'h77);
        req(1, 1'b1, 10'd299, 8'h11);
        req(1, 1'b1, 10'd300, 8'h22);
        req(1, 1'b1, 10'd900, 8'hC3);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        repeat (300) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("mid_dout", 32'(dout[1]), 32'd0);
        chk("mid_ack", 32'(ack[1]), 32'd0);
        chk("mid_busy", 32'(busy[1]), 32'd0);
        chk("mid_cdone", 32'(cdone[1]), 32'd0);
        for (int k = 0; k < 300; k++) model[1][k] = 8'h00;
        req(1, 1'b0, 10'd100, 8'd0);
        req(1, 1'b0, 10'd299, 8'd0);
        req(1, 1'b0, 10'd300, 8'd0);
        req(1, 1'b0, 10'd900, 8'd0);
        repeat (1100) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
